// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Arbitrates between two masters and one memory port: m0 is the UART programmer and
// m1 is the core. The port has a registered owner. Ownership changes only after every
// read issued by the current owner has returned, so each response reaches the master
// that issued the read. While prog_active_i is high, m1 is locked out.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   m0_* / m1_*                master request channels: req, we, addr, wdata, wstrb in;
//                              gnt, rvalid, rdata out
//   prog_active_i              programmer mode; masks m1 requests and responses
//   mem_* (out)                forwarded request: req, we, addr, wdata, wstrb
//   mem_gnt_i, mem_rvalid_i,
//   mem_rdata_i                memory handshake and in-order read response
//   owner_o                    current or last owner (0 = m0, 1 = m1)
//   busy_o                     not idle, or reads still outstanding
//   err_o                      sticky: a response arrived with no read outstanding
module mem_port_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 128,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned MAX_BURST       = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,

  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  output logic                m0_gnt_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,

  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  output logic                m1_gnt_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,

  input  logic                prog_active_i,

  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,

  output logic                owner_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {StIdle, StGrant, StDrain} state_e;

  state_e             r_state;
  logic               r_owner;
  logic               r_last_owner;
  logic [BURST_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0]   r_outstanding;
  logic               r_err;

  logic               w_m1_req;
  logic               w_sel;
  logic               w_own_req;
  logic               w_own_we;
  logic [ADDR_W-1:0]  w_own_addr;
  logic [DATA_W-1:0]  w_own_wdata;
  logic [STRB_W-1:0]  w_own_wstrb;
  logic               w_other_req;
  logic               w_burst_full;
  logic               w_burst_stop;
  logic               w_rd_full;
  logic               w_read_block;
  logic               w_leave;
  logic               w_fwd;
  logic               w_accept;
  logic               w_rd_accept;
  logic               w_rvalid_ok;

  assign w_m1_req = m1_req_i & ~prog_active_i;

  // Owner mux; only meaningful while in StGrant.
  assign w_own_req   = r_owner ? w_m1_req   : m0_req_i;
  assign w_own_we    = r_owner ? m1_we_i    : m0_we_i;
  assign w_own_addr  = r_owner ? m1_addr_i  : m0_addr_i;
  assign w_own_wdata = r_owner ? m1_wdata_i : m0_wdata_i;
  assign w_own_wstrb = r_owner ? m1_wstrb_i : m0_wstrb_i;
  assign w_other_req = r_owner ? m0_req_i   : w_m1_req;

  assign w_sel = rst_ni & (r_state == StGrant);

  // Once the burst budget is spent and the other side waits, stop forwarding right away
  // so the owner gets exactly MAX_BURST transactions before the handoff.
  assign w_burst_full = (r_burst_cnt == BURST_W'(MAX_BURST));
  assign w_burst_stop = w_other_req & w_burst_full;

  // A response in the same cycle frees a slot, so a read may be accepted at the cap.
  assign w_rd_full    = (r_outstanding == CNT_W'(MAX_OUTSTANDING));
  assign w_read_block = ~w_own_we & w_rd_full & ~mem_rvalid_i;

  assign w_leave = ~w_own_req | w_burst_stop | (r_owner & prog_active_i);

  assign w_fwd       = w_sel & w_own_req & ~w_burst_stop & ~w_read_block;
  assign w_accept    = w_fwd & mem_gnt_i;
  assign w_rd_accept = w_accept & ~w_own_we;

  // Responses with nothing outstanding are dropped.
  assign w_rvalid_ok = mem_rvalid_i & (r_outstanding != '0);

  assign mem_req_o   = w_fwd;
  assign mem_we_o    = w_sel & w_own_we;
  assign mem_addr_o  = w_sel ? w_own_addr  : '0;
  assign mem_wdata_o = w_sel ? w_own_wdata : '0;
  assign mem_wstrb_o = w_sel ? w_own_wstrb : '0;

  assign m0_gnt_o = w_accept & ~r_owner;
  assign m1_gnt_o = w_accept & r_owner;

  assign m0_rvalid_o = rst_ni & w_rvalid_ok & ~r_owner;
  assign m1_rvalid_o = rst_ni & w_rvalid_ok & r_owner & ~prog_active_i;
  assign m0_rdata_o  = (rst_ni & ~r_owner) ? mem_rdata_i : '0;
  assign m1_rdata_o  = (rst_ni & r_owner)  ? mem_rdata_i : '0;

  assign owner_o = r_owner;
  assign busy_o  = rst_ni & ((r_state != StIdle) | (r_outstanding != '0));
  assign err_o   = r_err;

  // Ownership state machine.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= StIdle;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_burst_cnt  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (m0_req_i && w_m1_req) begin
            r_owner     <= ~r_last_owner;
            r_burst_cnt <= '0;
            r_state     <= StGrant;
          end else if (m0_req_i) begin
            r_owner     <= 1'b0;
            r_burst_cnt <= '0;
            r_state     <= StGrant;
          end else if (w_m1_req) begin
            r_owner     <= 1'b1;
            r_burst_cnt <= '0;
            r_state     <= StGrant;
          end
        end
        StGrant: begin
          // Saturates so a long uncontested run cannot wrap the budget.
          if (w_accept && !w_burst_full) begin
            r_burst_cnt <= r_burst_cnt + BURST_W'(1);
          end
          if (w_leave) begin
            r_state <= StDrain;
          end
        end
        StDrain: begin
          if (r_outstanding == '0) begin
            r_last_owner <= r_owner;
            r_state      <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Outstanding-read counter and sticky stray-response flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      case ({w_rd_accept, w_rvalid_ok})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      if (mem_rvalid_i && (r_outstanding == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
